// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: decodes tv80 memory/IO cycles into ROM, banked RAM and 6850 SIO
// strobes, muxes the CPU read bus and inserts programmable wait states.
module z80_bus_ctrl #(
  parameter int                   ROM_ADDR_WIDTH = 13,
  parameter int                   BANK_BITS      = 2,
  parameter int                   WIN_BITS       = 14,
  parameter logic [15-WIN_BITS:0] WIN_SEL        = 2'b11,
  parameter logic [7:0]           IO_CTRL_PORT   = 8'h40,
  parameter logic [7:0]           IO_SIO_BASE    = 8'h80,
  parameter int                   MEM_WAIT       = 0,
  parameter int                   IO_WAIT        = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             addr,
  input  logic                    mreq_n,
  input  logic                    iorq_n,
  input  logic                    rd_n,
  input  logic                    wr_n,
  input  logic                    m1_n,
  input  logic                    rfsh_n,
  input  logic [7:0]              cpu_dout,
  output logic [7:0]              cpu_din,
  output logic                    wait_n,
  input  logic [7:0]              rom_dout,
  input  logic [7:0]              ram_dout,
  input  logic [7:0]              sio_dout,
  output logic                    rom_rd,
  output logic                    ram_rd,
  output logic                    ram_we,
  output logic [16+BANK_BITS-1:0] ram_addr,
  output logic                    sio_rd,
  output logic                    sio_we,
  output logic                    sio_addr,
  output logic                    rom_on
);

  localparam logic [3:0]  MEM_W     = 4'(MEM_WAIT);
  localparam logic [3:0]  IO_W      = 4'(IO_WAIT);
  localparam logic [16:0] ROM_LIMIT = 17'd1 << ROM_ADDR_WIDTH;

  logic                 mem_cyc_s, io_cyc_s, inta_s, req_s, start_s;
  logic                 req_r, io_done_r, rom_on_r;
  logic [3:0]           wait_cfg_s, cnt_r;
  logic [BANK_BITS-1:0] bank_r;
  logic                 wait_n_s, io_go_s;
  logic                 rom_hit_s, rom_sel_s, win_hit_s, sio_hit_s, ctrl_hit_s;
  logic [7:0]           status_s, din_s;
  logic                 unused_s;

  assign mem_cyc_s  = ~mreq_n & rfsh_n;
  assign io_cyc_s   = ~iorq_n & m1_n;
  assign inta_s     = ~iorq_n & ~m1_n;
  assign req_s      = mem_cyc_s | io_cyc_s;
  assign start_s    = req_s & ~req_r;
  assign wait_cfg_s = mem_cyc_s ? MEM_W : IO_W;

  // Reset forces wait_n high at once, without waiting for the counter to clear.
  assign wait_n_s = ~reset_n | ~((start_s & (wait_cfg_s != 4'd0)) | (cnt_r != 4'd0));
  assign io_go_s  = reset_n & io_cyc_s & wait_n_s & ~io_done_r;

  assign rom_hit_s  = ({1'b0, addr} < ROM_LIMIT);
  assign rom_sel_s  = rom_on_r & rom_hit_s;
  assign win_hit_s  = (addr[15:WIN_BITS] == WIN_SEL);
  assign sio_hit_s  = (addr[7:1] == IO_SIO_BASE[7:1]);
  assign ctrl_hit_s = (addr[7:0] == IO_CTRL_PORT);
  assign unused_s   = ^cpu_dout;

  assign rom_rd   = mem_cyc_s & ~rd_n & rom_sel_s;
  assign ram_rd   = mem_cyc_s & ~rd_n & ~rom_sel_s;
  assign ram_we   = mem_cyc_s & ~wr_n & wait_n_s;
  assign ram_addr = win_hit_s ? {bank_r, addr} : {{BANK_BITS{1'b0}}, addr};
  assign sio_rd   = io_go_s & sio_hit_s & ~rd_n;
  assign sio_we   = io_go_s & sio_hit_s & ~wr_n;
  assign sio_addr = addr[0];
  assign wait_n   = wait_n_s;
  assign rom_on   = rom_on_r;
  assign cpu_din  = din_s;

  // Control-port status byte: overlay-disabled flag on top, bank in the low bits.
  always_comb begin
    status_s                  = 8'h00;
    status_s[7]               = ~rom_on_r;
    status_s[BANK_BITS-1:0]   = bank_r;
  end

  // CPU read-data mux.
  always_comb begin
    din_s = 8'hFF;
    if (inta_s) begin
      din_s = 8'hFF;
    end else if (mem_cyc_s) begin
      if (rom_sel_s) din_s = rom_dout;
      else           din_s = ram_dout;
    end else if (io_cyc_s) begin
      if (sio_hit_s)       din_s = sio_dout;
      else if (ctrl_hit_s) din_s = status_s;
      else                 din_s = 8'hFF;
    end else begin
      din_s = 8'hFF;
    end
  end

  // Cycle-start edge detect and one-strobe-per-IO-access tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_r     <= 1'b0;
      io_done_r <= 1'b0;
    end else begin
      req_r <= req_s;
      if (!req_s)       io_done_r <= 1'b0;
      else if (io_go_s) io_done_r <= 1'b1;
      else              io_done_r <= io_done_r;
    end
  end

  // Wait-state counter: the start cycle is the first low cycle, so load W-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 4'd0;
    end else if (start_s && (wait_cfg_s != 4'd0)) begin
      cnt_r <= wait_cfg_s - 4'd1;
    end else if (cnt_r != 4'd0) begin
      if (req_s) cnt_r <= cnt_r - 4'd1;
      else       cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Control register: overlay disable is sticky until reset; bank applies from the next clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_on_r <= 1'b1;
      bank_r   <= {BANK_BITS{1'b0}};
    end else if (io_go_s && ctrl_hit_s && !wr_n) begin
      rom_on_r <= rom_on_r & ~cpu_dout[7];
      bank_r   <= cpu_dout[BANK_BITS-1:0];
    end else begin
      rom_on_r <= rom_on_r;
      bank_r   <= bank_r;
    end
  end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Directed self-checking bench for z80_bus_ctrl (IO_WAIT=3, MEM_WAIT=0).
module tb_z80_bus_ctrl;

  logic        clk, reset_n;
  logic [15:0] addr;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [7:0]  cpu_dout, cpu_din;
  logic        wait_n;
  logic [7:0]  rom_dout, ram_dout, sio_dout;
  logic        rom_rd, ram_rd, ram_we;
  logic [17:0] ram_addr;
  logic        sio_rd, sio_we, sio_addr, rom_on;

  int total = 0;
  int fails = 0;

  logic [5:0] exp_wait;
  logic [5:0] exp_sio;

  z80_bus_ctrl #(.MEM_WAIT(0), .IO_WAIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .wait_n(wait_n),
    .rom_dout(rom_dout), .ram_dout(ram_dout), .sio_dout(sio_dout),
    .rom_rd(rom_rd), .ram_rd(ram_rd), .ram_we(ram_we), .ram_addr(ram_addr),
    .sio_rd(sio_rd), .sio_we(sio_we), .sio_addr(sio_addr), .rom_on(rom_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic io_access(input logic [15:0] a, input logic wr, input logic [7:0] d, input int cycles);
    addr = a; cpu_dout = d; iorq_n = 1'b0;
    if (wr) wr_n = 1'b0;
    else    rd_n = 1'b0;
    repeat (cycles) tick();
    idle();
    tick();
  endtask

  initial begin
    reset_n = 1'b0; addr = 16'h0000; cpu_dout = 8'h00;
    rom_dout = 8'hA5; ram_dout = 8'h3C; sio_dout = 8'h96;
    idle();
    #12;
    chk("rst_rom_on", rom_on, 1);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_din", cpu_din, 8'hFF);
    chk("rst_enables", {rom_rd, ram_rd, ram_we, sio_rd, sio_we}, 5'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // ROM overlay read and write-under-ROM
    addr = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0; #1;
    chk("rom_rd", rom_rd, 1);
    chk("rom_din", cpu_din, 8'hA5);
    chk("rom_ram_rd", ram_rd, 0);
    tick(); idle(); tick();
    addr = 16'h0100; cpu_dout = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0; #1;
    chk("wur_ram_we", ram_we, 1);
    chk("wur_ram_addr", ram_addr, 18'h00100);
    chk("wur_rom_rd", rom_rd, 0);
    tick(); idle(); tick();

    // OUT (0x40),0x82: overlay off, bank 2
    io_access(16'h0040, 1'b1, 8'h82, 6);
    chk("ctrl_rom_on", rom_on, 0);
    addr = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0; #1;
    chk("lo_ram_rd", ram_rd, 1);
    chk("lo_rom_rd", rom_rd, 0);
    chk("lo_ram_addr", ram_addr, 18'h00100);
    chk("lo_din", cpu_din, 8'h3C);
    tick(); idle(); tick();
    addr = 16'hC123; mreq_n = 1'b0; rd_n = 1'b0; #1;
    chk("win_ram_addr", ram_addr, 18'h2C123);
    tick(); idle(); tick();
    addr = 16'h0040; iorq_n = 1'b0; rd_n = 1'b0; #1;
    chk("ctrl_status", cpu_din, 8'h82);
    tick(); idle(); tick();

    // IN 0x81 held 6 clocks: three wait cycles, then a single sio_rd
    exp_wait = 6'b111000;
    exp_sio  = 6'b001000;
    addr = 16'h0081; iorq_n = 1'b0; rd_n = 1'b0; #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("sio_wait_c%0d", k), wait_n, exp_wait[k]);
      chk($sformatf("sio_rd_c%0d", k), sio_rd, exp_sio[k]);
      if (k == 0) begin
        chk("sio_addr", sio_addr, 1);
        chk("sio_din", cpu_din, 8'h96);
      end
      @(posedge clk); #2;
    end
    idle(); tick();

    // zero-wait memory cycle and refresh
    addr = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0; #1;
    chk("mem_nowait0", wait_n, 1);
    tick();
    chk("mem_nowait1", wait_n, 1);
    idle(); tick();
    addr = 16'h0100; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; #1;
    chk("rfsh_enables", {rom_rd, ram_rd, ram_we, sio_rd, sio_we}, 5'b0);
    chk("rfsh_wait", wait_n, 1);
    tick(); idle(); tick();

    // interrupt acknowledge on an SIO-looking address
    addr = 16'h0081; m1_n = 1'b0; iorq_n = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("inta_din_c%0d", k), cpu_din, 8'hFF);
      chk($sformatf("inta_sio_c%0d", k), {sio_rd, sio_we}, 2'b00);
      chk($sformatf("inta_wait_c%0d", k), wait_n, 1);
      tick();
    end
    idle(); tick();
    addr = 16'h0022; iorq_n = 1'b0; rd_n = 1'b0; #1;
    chk("unmapped_in", cpu_din, 8'hFF);
    tick(); idle(); tick();

    // reset during a counted SIO write wait
    addr = 16'h0081; cpu_dout = 8'h11; iorq_n = 1'b0; wr_n = 1'b0; #1;
    chk("mid_wait0", wait_n, 0);
    tick();
    chk("mid_wait1", wait_n, 0);
    reset_n = 1'b0; #1;
    chk("mid_rst_wait_n", wait_n, 1);
    chk("mid_rst_rom_on", rom_on, 1);
    chk("mid_rst_sio_we", sio_we, 0);
    tick();
    idle(); #1;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_rst_sio_we_c%0d", k), sio_we, 0);
      tick();
    end
    addr = 16'h0040; iorq_n = 1'b0; rd_n = 1'b0; #1;
    chk("post_rst_status", cpu_din, 8'h00);
    tick(); idle(); tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
Parametrised Z80 bus controller for the single-board-computer tops: decodes tv80 memory/IO cycles into ROM, banked RAM and 6850 SIO strobes, muxes the CPU read bus, and inserts programmable wait states. Adds a boot-ROM overlay that is disabled by software, a RAM bank register, single-cycle IO strobes, and interrupt-acknowledge handling. It sits between the tv80n core and the rom_memory, ram_memory and mc6850 instances.

Parameters:
ROM_ADDR_WIDTH, 13, ROM overlay size is 2^ROM_ADDR_WIDTH bytes at 0x0000
BANK_BITS, 2, width of the RAM bank register (1..7)
WIN_BITS, 14, banked window is addr[15:WIN_BITS] == WIN_SEL
WIN_SEL, 2'b11, selects the banked window (default 0xC000-0xFFFF)
IO_CTRL_PORT, 8'h40, control/bank register IO address
IO_SIO_BASE, 8'h80, SIO base address (even); the SIO occupies BASE and BASE+1
MEM_WAIT, 0, wait states per memory cycle (0..15)
IO_WAIT, 1, wait states per IO cycle (0..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr  in  16  CPU address
mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  CPU strobes
cpu_dout  in  8  CPU write data
cpu_din  out  8  CPU read data
wait_n  out  1  to CPU wait_n
rom_dout, ram_dout, sio_dout  in  8 each  device read data
rom_rd  out  1  ROM read enable
ram_rd, ram_we  out  1 each  RAM read/write enables
ram_addr  out  16+BANK_BITS  physical RAM address
sio_rd, sio_we  out  1 each  SIO strobes (one-cycle pulses)
sio_addr  out  1  SIO register select (addr[0])
rom_on  out  1  overlay status

Behaviour:
- Reset (async, reset_n=0): rom_on=1, bank=0, wait counter=0, req_q=0, io_done=0. All strobe outputs are 0 while the CPU strobes are inactive, and wait_n=1.
- mem_cyc = ~mreq_n & rfsh_n. Refresh cycles decode nothing. io_cyc = ~iorq_n & m1_n. inta = ~iorq_n & ~m1_n.
- req = mem_cyc | io_cyc. start = req & ~req_q, where req_q is req registered.
- Wait generator: W is MEM_WAIT or IO_WAIT according to the cycle type.
  - On start with W>0, load cnt = W-1. While cnt != 0, decrement each clk.
  - wait_n = ~((start & W>0) | cnt != 0), which gives exactly W low cycles beginning at the start cycle.
  - If req drops while cnt != 0, clear cnt on the next clk. inta never waits.
- Memory decode, combinational:
  - Read with rom_on=1 and addr < 2^ROM_ADDR_WIDTH: rom_rd = ~rd_n, cpu_din = rom_dout.
  - Any other memory read: ram_rd = ~rd_n, cpu_din = ram_dout.
  - Writes always go to RAM (write-under-ROM): ram_we = ~wr_n & wait_n. This is a level signal.
  - ram_addr = {bank, addr} when addr[15:WIN_BITS] == WIN_SEL, else {BANK_BITS'b0, addr}. Bank 0 window is therefore linear.
- IO decode uses addr[7:0] only. io_go = io_cyc & wait_n & ~io_done.
  - io_done is set on the clk where io_go=1 and cleared when req=0. Each IO access therefore produces exactly one strobe cycle.
  - SIO (addr[7:1] == IO_SIO_BASE[7:1]): sio_rd = io_go & ~rd_n, sio_we = io_go & ~wr_n, sio_addr = addr[0]. cpu_din = sio_dout for the whole cycle.
  - IO_CTRL_PORT write on io_go: if cpu_dout[7]=1, clear rom_on (sticky until reset). bank <= cpu_dout[BANK_BITS-1:0].
  - IO_CTRL_PORT read: cpu_din = {~rom_on, zero pad, bank}.
  - Unmapped IO read returns 8'hFF. Unmapped writes are ignored.
- inta: cpu_din = 8'hFF (RST 38h), no device strobes.
- No cycle active: cpu_din = 8'hFF, all enables 0.
- A bank write takes effect from the next clk, so a following M1 fetch uses the new bank.
- A reset asserted mid-cycle immediately forces wait_n=1 and kills pending strobes via cnt/io_done. Combinational decode follows the now-reset rom_on and bank.

Test Plan:
- Reset, then read 0x0100 -> rom_rd=1, cpu_din=rom_dout. Write 0x0100 ← 0x5A -> ram_we=1, ram_addr=0x00100, rom_rd=0.
- OUT (0x40),0x82, then read 0x0100 and 0xC123 -> rom_on=0, ram_rd at 0x00100. Window read ram_addr=0x2C123 (bank 2). IN 0x40 -> 0x82.
- IO_WAIT=3, IN 0x81 held 6 clk -> wait_n low exactly 3 clk from start. sio_rd high exactly 1 clk, in the first cycle with wait_n=1. sio_addr=1.
- Memory cycle with MEM_WAIT=0 -> wait_n stays 1. Refresh cycle (rfsh_n=0, mreq_n=0) -> no enables asserted.
- Interrupt ack (m1_n=0, iorq_n=0) -> cpu_din=0xFF, no sio_* pulse. IN 0x22 -> 0xFF.
- reset_n pulsed low during a counted IO wait -> wait_n=1 asynchronously, rom_on=1, bank=0, no sio_we pulse afterwards.
